// File: rtl/bilinear_downsample_ctrl.sv
`default_nettype none
// ============================================================================
// bilinear_downsample_ctrl -- raster-scan sequencer for bilinear downsampling.
// Optional feature macro: BILIN_DS_STALL_CNT_EN (adds 32-bit stall_cnt port).
// Revision: 1.0
// ============================================================================
module bilinear_downsample_ctrl #(
   parameter int ADDR_W = 12,
   parameter int DIM_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DIM_W-1:0]  in_w,
   input  logic [DIM_W-1:0]  in_h,
   input  logic [DIM_W-1:0]  out_w,
   input  logic [DIM_W-1:0]  out_h,
   input  logic [15:0]       step_x,
   input  logic [15:0]       step_y,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic [15:0]       ip_x,
   output logic [15:0]       ip_y,
   output logic [7:0]        ip_a1,
   output logic [7:0]        ip_a2,
   output logic [7:0]        ip_a3,
   output logic [7:0]        ip_a4,
   input  logic [7:0]        ip_v,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done
`ifdef BILIN_DS_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_CALC  = 3'd3,
      S_OUT   = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        k_q, k_d;
   logic [15:0]       ax_q, ax_d, ay_q, ay_d;
   logic [DIM_W-1:0]  ox_q, ox_d, oy_q, oy_d;
   logic [DIM_W-1:0]  in_w_q, in_w_d, in_h_q, in_h_d;
   logic [DIM_W-1:0]  out_w_q, out_w_d, out_h_q, out_h_d;
   logic [15:0]       step_x_q, step_x_d, step_y_q, step_y_d;
   logic [7:0]        a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
   logic [15:0]       ip_x_q, ip_x_d, ip_y_q, ip_y_d;
   logic [7:0]        ip_a1_q, ip_a1_d, ip_a2_q, ip_a2_d;
   logic [7:0]        ip_a3_q, ip_a3_d, ip_a4_q, ip_a4_d;
   logic [7:0]        out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

   // Neighbour k (0..3 = a1..a4) address; integer part is clamped to the map edge.
   function automatic logic [ADDR_W-1:0] nb_addr(
      input logic [15:0]      ax,
      input logic [15:0]      ay,
      input logic [DIM_W-1:0] w,
      input logic [DIM_W-1:0] h,
      input logic [1:0]       k
   );
      logic [DIM_W-1:0]   x0, x1, y0, y1, col, row;
      logic [2*DIM_W-1:0] lin;
      x0 = DIM_W'(ax[15:8]);
      y0 = DIM_W'(ay[15:8]);
      if (x0 >= w - ONE) begin
         x0 = w - ONE;
         x1 = x0;
      end else begin
         x1 = x0 + ONE;
      end
      if (y0 >= h - ONE) begin
         y0 = h - ONE;
         y1 = y0;
      end else begin
         y1 = y0 + ONE;
      end
      col = k[0] ? x1 : x0;
      row = k[1] ? y1 : y0;
      lin = (2*DIM_W)'(row) * (2*DIM_W)'(w) + (2*DIM_W)'(col);
      return ADDR_W'(lin);
   endfunction

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      ax_d       = ax_q;
      ay_d       = ay_q;
      ox_d       = ox_q;
      oy_d       = oy_q;
      in_w_d     = in_w_q;
      in_h_d     = in_h_q;
      out_w_d    = out_w_q;
      out_h_d    = out_h_q;
      step_x_d   = step_x_q;
      step_y_d   = step_y_q;
      a1_d       = a1_q;
      a2_d       = a2_q;
      a3_d       = a3_q;
      ip_x_d     = ip_x_q;
      ip_y_d     = ip_y_q;
      ip_a1_d    = ip_a1_q;
      ip_a2_d    = ip_a2_q;
      ip_a3_d    = ip_a3_q;
      ip_a4_d    = ip_a4_q;
      out_data_d = out_data_q;
      out_last_d = out_last_q;
      rd_en_d    = 1'b0;
      rd_addr_d  = rd_addr_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               in_w_d   = in_w;
               in_h_d   = in_h;
               out_w_d  = out_w;
               out_h_d  = out_h;
               step_x_d = step_x;
               step_y_d = step_y;
               ax_d     = 16'd0;
               ay_d     = 16'd0;
               ox_d     = '0;
               oy_d     = '0;
               k_d      = 2'd0;
               state_d  = (out_w == '0 || out_h == '0) ? S_FIN : S_FETCH;
            end
         end
         S_FETCH: begin
            // Read data trails the strobe by one cycle, so slot k holds neighbour k-1.
            case (k_q)
               2'd1:    a1_d = rd_data;
               2'd2:    a2_d = rd_data;
               2'd3:    a3_d = rd_data;
               default: ;
            endcase
            if (k_q == 2'd3) begin
               state_d = S_WAIT;
            end else begin
               k_d = k_q + 2'd1;
            end
         end
         S_WAIT: begin
            ip_x_d  = ax_q;
            ip_y_d  = ay_q;
            ip_a1_d = a1_q;
            ip_a2_d = a2_q;
            ip_a3_d = a3_q;
            ip_a4_d = rd_data;
            state_d = S_CALC;
         end
         S_CALC: begin
            out_data_d = ip_v;
            out_last_d = (ox_q == out_w_q - ONE) && (oy_q == out_h_q - ONE);
            state_d    = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               if (ox_q == out_w_q - ONE) begin
                  ox_d = '0;
                  ax_d = 16'd0;
                  oy_d = oy_q + ONE;
                  ay_d = ay_q + step_y_q;
               end else begin
                  ox_d = ox_q + ONE;
                  ax_d = ax_q + step_x_q;
               end
               k_d     = 2'd0;
               state_d = out_last_q ? S_FIN : S_FETCH;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Registered strobe/address track the state being entered so they align with it.
      rd_en_d = (state_d == S_FETCH);
      if (rd_en_d) begin
         rd_addr_d = nb_addr(ax_d, ay_d, in_w_d, in_h_d, k_d);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         k_q        <= 2'd0;
         ax_q       <= 16'd0;
         ay_q       <= 16'd0;
         ox_q       <= '0;
         oy_q       <= '0;
         in_w_q     <= '0;
         in_h_q     <= '0;
         out_w_q    <= '0;
         out_h_q    <= '0;
         step_x_q   <= 16'd0;
         step_y_q   <= 16'd0;
         a1_q       <= 8'd0;
         a2_q       <= 8'd0;
         a3_q       <= 8'd0;
         ip_x_q     <= 16'd0;
         ip_y_q     <= 16'd0;
         ip_a1_q    <= 8'd0;
         ip_a2_q    <= 8'd0;
         ip_a3_q    <= 8'd0;
         ip_a4_q    <= 8'd0;
         out_data_q <= 8'd0;
         out_last_q <= 1'b0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         ax_q       <= ax_d;
         ay_q       <= ay_d;
         ox_q       <= ox_d;
         oy_q       <= oy_d;
         in_w_q     <= in_w_d;
         in_h_q     <= in_h_d;
         out_w_q    <= out_w_d;
         out_h_q    <= out_h_d;
         step_x_q   <= step_x_d;
         step_y_q   <= step_y_d;
         a1_q       <= a1_d;
         a2_q       <= a2_d;
         a3_q       <= a3_d;
         ip_x_q     <= ip_x_d;
         ip_y_q     <= ip_y_d;
         ip_a1_q    <= ip_a1_d;
         ip_a2_q    <= ip_a2_d;
         ip_a3_q    <= ip_a3_d;
         ip_a4_q    <= ip_a4_d;
         out_data_q <= out_data_d;
         out_last_q <= out_last_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
      end
   end

   assign rd_en     = rd_en_q;
   assign rd_addr   = rd_addr_q;
   assign ip_x      = ip_x_q;
   assign ip_y      = ip_y_q;
   assign ip_a1     = ip_a1_q;
   assign ip_a2     = ip_a2_q;
   assign ip_a3     = ip_a3_q;
   assign ip_a4     = ip_a4_q;
   assign out_valid = (state_q == S_OUT);
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                      (state_q == S_CALC)  || (state_q == S_OUT);
   assign done      = (state_q == S_FIN);

`ifdef BILIN_DS_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (state_q == S_IDLE && start) begin
         stall_cnt_d = 32'd0;
      end else if (out_valid && !out_ready && stall_cnt_q != 32'hFFFF_FFFF) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bilinear_downsample_ctrl.sv
`default_nettype none
// Self-checking bench for bilinear_downsample_ctrl: feature-map buffer and
// interpolator models, directed test-plan maps, then randomized maps.
module tb_bilinear_downsample_ctrl;
   localparam int ADDR_W = 12;
   localparam int DIM_W  = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [DIM_W-1:0]  in_w = '0, in_h = '0, out_w = '0, out_h = '0;
   logic [15:0]       step_x = '0, step_y = '0;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data = '0;
   logic [15:0]       ip_x, ip_y;
   logic [7:0]        ip_a1, ip_a2, ip_a3, ip_a4;
   logic [7:0]        ip_v;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [7:0]        out_data;
   logic              out_last;
   logic              busy, done;
`ifdef BILIN_DS_STALL_CNT_EN
   logic [31:0]       stall_cnt;
`endif

   bilinear_downsample_ctrl #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_w(in_w), .in_h(in_h), .out_w(out_w), .out_h(out_h),
      .step_x(step_x), .step_y(step_y),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .ip_x(ip_x), .ip_y(ip_y),
      .ip_a1(ip_a1), .ip_a2(ip_a2), .ip_a3(ip_a3), .ip_a4(ip_a4),
      .ip_v(ip_v),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done)
`ifdef BILIN_DS_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:4095];
   int addr_q[$];
   int n_cmp = 0;
   int n_fail = 0;

   // Single-port buffer: data one cycle after the strobe; every read is logged.
   always @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_addr];
         addr_q.push_back(int'(rd_addr));
      end
   end

   // Bilinear blend with 8-bit fractions, truncated toward zero.
   function automatic logic [7:0] interp(input int a1, a2, a3, a4, fx, fy);
      int top, bot;
      top = a1 * (256 - fx) + a2 * fx;
      bot = a3 * (256 - fx) + a4 * fx;
      return 8'((top * (256 - fy) + bot * fy) >> 16);
   endfunction

   always_comb ip_v = interp(int'(ip_a1), int'(ip_a2), int'(ip_a3), int'(ip_a4),
                             int'(ip_x[7:0]), int'(ip_y[7:0]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_ip_xy"}, {ip_x, ip_y}, 0);
      chk({tag, "_ip_a"}, {ip_a1, ip_a2, ip_a3, ip_a4}, 0);
      chk({tag, "_out"}, {out_valid, out_last, out_data}, 0);
      chk({tag, "_busy_done"}, {busy, done}, 0);
`ifdef BILIN_DS_STALL_CNT_EN
      chk({tag, "_stall_cnt"}, stall_cnt, 0);
`endif
   endtask

   task automatic fill_pattern();
      for (int i = 0; i < 4096; i++) mem[i] = 8'(16 * (i / 4) + (i % 4));
   endtask

   task automatic fill_random();
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
   endtask

   // mode 0: out_ready high; 1: 5-cycle stall on the first pixel;
   // 2: random stalls plus spurious start pulses / config churn while busy.
   task automatic run_map(input int iw, ih, ow, oh, sx, sy, mode);
      int lat, stl, tot_stall, ex, ey, x0, x1, y0, y1;
      int ea[4];
      logic [7:0] held;
      logic       last;
      in_w = DIM_W'(iw); in_h = DIM_W'(ih); out_w = DIM_W'(ow); out_h = DIM_W'(oh);
      step_x = 16'(sx); step_y = 16'(sy);
      addr_q.delete();
      tot_stall = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      for (int oy = 0; oy < oh; oy++) begin
         for (int ox = 0; ox < ow; ox++) begin
            last = (oy == oh - 1) && (ox == ow - 1);
            stl = (mode == 1 && ox == 0 && oy == 0) ? 5 :
                  (mode == 2) ? int'($urandom_range(0, 3)) : 0;
            out_ready = (stl == 0);
            if (mode == 2 && $urandom_range(0, 2) == 0) begin
               start = 1'b1;
               in_w  = DIM_W'($urandom_range(1, 30));
            end
            lat = (ox == 0 && oy == 0) ? 1 : 0;
            while (!out_valid && lat < 40) begin
               @(negedge clk);
               lat++;
            end
            // First pixel: OUT is the 8th cycle counting the start cycle; later: 7-cycle period.
            chk("pix_latency", lat, (ox == 0 && oy == 0) ? 7 : 6);
            if (!out_valid) return;

            ex = (ox * sx) & 16'hFFFF;
            ey = (oy * sy) & 16'hFFFF;
            x0 = ex >> 8;
            y0 = ey >> 8;
            if (x0 >= iw - 1) begin x0 = iw - 1; x1 = x0; end else x1 = x0 + 1;
            if (y0 >= ih - 1) begin y0 = ih - 1; y1 = y0; end else y1 = y0 + 1;
            ea[0] = (y0 * iw + x0) % 4096;
            ea[1] = (y0 * iw + x1) % 4096;
            ea[2] = (y1 * iw + x0) % 4096;
            ea[3] = (y1 * iw + x1) % 4096;
            chk("n_reads", addr_q.size(), 4);
            for (int k = 0; k < 4; k++)
               chk("rd_addr_seq", (addr_q.size() > k) ? addr_q[k] : -1, ea[k]);
            addr_q.delete();
            chk("ip_x", ip_x, ex);
            chk("ip_y", ip_y, ey);
            chk("ip_a", {ip_a1, ip_a2, ip_a3, ip_a4},
                {mem[ea[0]], mem[ea[1]], mem[ea[2]], mem[ea[3]]});
            chk("out_data", out_data,
                interp(mem[ea[0]], mem[ea[1]], mem[ea[2]], mem[ea[3]], ex & 255, ey & 255));
            chk("out_last", out_last, last);
            held = out_data;
            if (stl > 0) begin
               for (int i = 0; i < stl; i++) begin
                  @(negedge clk);
                  chk("stall_valid", out_valid, 1);
                  chk("stall_data", out_data, held);
                  chk("stall_last", out_last, last);
                  chk("stall_rd_en", rd_en, 0);
               end
               out_ready = 1'b1;
            end
            tot_stall += stl;
            @(negedge clk);
            out_ready = 1'b0;
            start = 1'b0;
            if (last) begin
               chk("done_pulse", done, 1);
               chk("busy_fin", busy, 0);
               chk("valid_fin", out_valid, 0);
            end else begin
               chk("done_mid", done, 0);
            end
         end
      end
`ifdef BILIN_DS_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, tot_stall);
`endif
      @(negedge clk);
      chk("done_once", done, 0);
      chk("idle_busy", busy, 0);
      chk("extra_reads", addr_q.size(), 0);
   endtask

   initial begin
      int seen;
      // Reset state
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Directed maps on the 16r+c pattern
      fill_pattern();
      run_map(4, 4, 2, 2, 16'h0200, 16'h0200, 0);
      run_map(4, 4, 2, 1, 16'h0180, 16'h0100, 0);
      run_map(4, 4, 3, 1, 16'h0180, 16'h0100, 0);
      run_map(4, 4, 2, 2, 16'h0200, 16'h0200, 1);

      // Zero-size map, and a start in the FIN cycle must be ignored
      in_w = 8'd4; in_h = 8'd4; out_w = 8'd0; out_h = 8'd2;
      addr_q.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("zs_done", done, 1);
      chk("zs_busy", busy, 0);
      out_w = 8'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("zs_done_once", done, 0);
      chk("fin_start_ignored", busy, 0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         seen += int'(out_valid) + int'(rd_en);
      end
      chk("zs_no_activity", seen, 0);
      chk("zs_no_reads", addr_q.size(), 0);

      // Reset during the third FETCH cycle
      in_w = 8'd4; in_h = 8'd4; out_w = 8'd2; out_h = 8'd2;
      step_x = 16'h0200; step_y = 16'h0200;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_reset_rd_en", rd_en, 1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      @(negedge clk);
      chk("midreset_no_done", done, 0);
      rst_n = 1'b1;
      @(negedge clk);
      run_map(4, 4, 2, 2, 16'h0200, 16'h0200, 0);

      // Randomized maps; the last one uses a step that wraps the accumulator
      for (int t = 0; t < 6; t++) begin
         fill_random();
         run_map(int'($urandom_range(1, 16)), int'($urandom_range(1, 16)),
                 int'($urandom_range(1, 4)), int'($urandom_range(1, 3)),
                 (t == 5) ? 16'hF000 : int'($urandom_range(0, 16'h0600)),
                 int'($urandom_range(0, 16'h0600)), 2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
